timer_dev: RTL and testbench

- Memory-mapped programmable countdown timer; the responder on the processor bus (PrAddr/PrWD/PrWe/PrRD) that the CPU drives through the bridge.
- Holds CTRL, PRESET and COUNT registers and counts down from PRESET.
- On expiry raises IRQ, which the bridge feeds into one HWInt line of the CPU.
- Modes: 0 = one-shot, level IRQ held until software clears it; 1 = auto-reload, one-cycle IRQ pulse.

---
 rtl/timer_dev_pkg.sv | 13 +
 rtl/timer_dev.sv | 101 ++++++++++
 tb/tb_timer_dev.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: register map, CTRL fields, modes and FSM states for timer_dev
package timer_dev_pkg;
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
endpackage

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot and auto-reload modes
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic        PrWe,
    output logic [31:0] PrRD,
    output logic        IRQ
);
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_n;
    logic        irq_flag;
    logic        flag_set;
    logic        flag_clr;
    logic        en_clr;
    state_t      state;
    state_t      state_n;
    logic        hit;
    logic [1:0]  off;
    logic        we_ctrl;
    logic        we_preset;
    logic        unused_addr;
    assign unused_addr = ^PrAddr[1:0];
    assign hit       = PrAddr[31:4] == BASE[31:4];
    assign off       = PrAddr[3:2];
    assign we_ctrl   = PrWe & hit & (off == OFF_CTRL);
    assign we_preset = PrWe & hit & (off == OFF_PRESET);
    assign IRQ       = ctrl[CTRL_IM] & irq_flag;
    // Read mux: unmapped offset and misses return zero
    always_comb begin
        PrRD = !hit                 ? 32'd0 :
               off == OFF_CTRL      ? {28'd0, ctrl} :
               off == OFF_PRESET    ? preset :
               off == OFF_COUNT     ? count : 32'd0;
    end
    // FSM next state; MODE values other than reload behave as one-shot
    always_comb begin
        state_n  = state;
        count_n  = count;
        flag_set = 1'b0;
        flag_clr = 1'b0;
        en_clr   = 1'b0;
        case (state)
            IDLE: state_n = ctrl[CTRL_EN] ? LOAD : IDLE;
            LOAD: begin
                count_n = preset;
                state_n = CNT;
            end
            CNT: begin
                if (!ctrl[CTRL_EN]) begin
                    state_n = IDLE;
                end else if (count > 32'd1) begin
                    count_n = count - 32'd1;
                end else begin
                    count_n  = 32'd0;
                    flag_set = 1'b1;
                    state_n  = INT;
                end
            end
            INT: begin
                state_n  = IDLE;
                flag_clr = ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
                en_clr   = ctrl[CTRL_MODE_HI:CTRL_MODE_LO] != MODE_RELOAD;
            end
        endcase
    end
    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 32'd0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end
    // Software registers; a CTRL write overrides the FSM clearing EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl   <= 4'd0;
            preset <= 32'd0;
        end else begin
            if (we_ctrl) ctrl <= PrWD[3:0];
            else if (en_clr) ctrl[CTRL_EN] <= 1'b0;
            if (we_preset) preset <= PrWD;
        end
    end
    // Expiry flag; setting beats a clearing write so no expiry is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_flag <= 1'b0;
        else if (flag_set) irq_flag <= 1'b1;
        else if (we_ctrl | we_preset | flag_clr) irq_flag <= 1'b0;
    end
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed vectors and corner sequences for timer_dev
module tb_timer_dev;
    localparam logic [31:0] B = 32'h0000_7F00;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PrAddr = 32'd0;
    logic [31:0] PrWD = 32'd0;
    logic        PrWe = 1'b0;
    logic [31:0] PrRD;
    logic        IRQ;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        irq;
    } vec_t;
    vec_t v[17];

    always #5 clk = ~clk;

    timer_dev #(.BASE(B)) dut (
        .clk(clk), .reset(reset), .PrAddr(PrAddr), .PrWD(PrWD),
        .PrWe(PrWe), .PrRD(PrRD), .IRQ(IRQ)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_irq(input string nm, input logic exp);
        chk(nm, {31'd0, IRQ}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        PrAddr = a;
        PrWD   = d;
        PrWe   = 1'b1;
        tick();
        PrWe   = 1'b0;
    endtask

    task automatic rdchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        PrAddr = a;
        #1;
        chk(nm, PrRD, exp);
    endtask

    initial begin
        v[0]  = '{1'b0, B,                32'h0,        32'h0,        1'b0};
        v[1]  = '{1'b0, B + 32'h4,        32'h0,        32'h0,        1'b0};
        v[2]  = '{1'b0, B + 32'h8,        32'h0,        32'h0,        1'b0};
        v[3]  = '{1'b0, B + 32'hC,        32'h0,        32'h0,        1'b0};
        v[4]  = '{1'b0, 32'h0000_7F10,    32'h0,        32'h0,        1'b0};
        v[5]  = '{1'b1, B + 32'h4,        32'hDEADBEEF, 32'h0,        1'b0};
        v[6]  = '{1'b0, B + 32'h4,        32'h0,        32'hDEADBEEF, 1'b0};
        v[7]  = '{1'b1, B,                32'hFFFFFFF6, 32'h0,        1'b0};
        v[8]  = '{1'b0, B,                32'h0,        32'h6,        1'b0};
        v[9]  = '{1'b1, B + 32'h8,        32'h1234,     32'h0,        1'b0};
        v[10] = '{1'b0, B + 32'h8,        32'h0,        32'h0,        1'b0};
        v[11] = '{1'b1, B + 32'hC,        32'h5555,     32'h0,        1'b0};
        v[12] = '{1'b1, 32'h0000_7F14,    32'h1,        32'h0,        1'b0};
        v[13] = '{1'b0, B + 32'h5,        32'h0,        32'hDEADBEEF, 1'b0};
        v[14] = '{1'b0, 32'h0000_0F04,    32'h0,        32'h0,        1'b0};
        v[15] = '{1'b1, B,                32'h0,        32'h6,        1'b0};
        v[16] = '{1'b0, B,                32'h0,        32'h0,        1'b0};

        ticks(2);
        rdchk("rst_ctrl", B, 32'h0);
        chk_irq("rst_irq", 1'b0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 17; i++) begin
            PrAddr = v[i].addr;
            PrWD   = v[i].wd;
            PrWe   = v[i].we;
            #1;
            chk($sformatf("vec%0d_rd", i), PrRD, v[i].rd);
            chk_irq($sformatf("vec%0d_irq", i), v[i].irq);
            tick();
        end
        PrWe = 1'b0;

        wr(B + 32'h4, 32'd5);
        wr(B, 32'h9);
        ticks(2);
        for (int i = 0; i < 6; i++) begin
            rdchk("m0_count", B + 32'h8, 32'(5 - i));
            chk_irq("m0_irq", i == 5);
            tick();
        end
        rdchk("m0_ctrl_en_cleared", B, 32'h8);
        chk_irq("m0_irq_held", 1'b1);
        tick();
        chk_irq("m0_irq_held2", 1'b1);
        wr(B, 32'h8);
        chk_irq("m0_irq_cleared", 1'b0);
        rdchk("m0_ctrl_after", B, 32'h8);

        wr(B + 32'h4, 32'd0);
        wr(B, 32'h9);
        ticks(2);
        chk_irq("p0_irq_c2", 1'b0);
        tick();
        chk_irq("p0_irq_c3", 1'b1);
        wr(B, 32'h0);
        chk_irq("p0_irq_clr", 1'b0);

        wr(B + 32'h4, 32'd2);
        wr(B, 32'h9);
        ticks(3);
        rdchk("sim_count1", B + 32'h8, 32'd1);
        wr(B + 32'h4, 32'd7);
        chk_irq("sim_set_wins", 1'b1);
        rdchk("sim_count0", B + 32'h8, 32'd0);
        wr(B, 32'h9);
        rdchk("sim_sw_wins_ctrl", B, 32'h9);
        chk_irq("sim_irq_after", 1'b0);
        ticks(2);
        rdchk("sim_new_preset", B + 32'h8, 32'd7);
        wr(B, 32'h0);
        ticks(2);

        wr(B + 32'h4, 32'd3);
        wr(B, 32'hB);
        for (int c = 0; c < 26; c++) begin
            if (c >= 2) rdchk("m1_count", B + 32'h8, ((c - 2) % 6) <= 3 ? 32'(3 - (c - 2) % 6) : 32'd0);
            chk_irq("m1_irq", c >= 5 && (c - 5) % 6 == 0);
            tick();
        end
        wr(B, 32'h0);
        ticks(2);

        wr(B + 32'h4, 32'd10);
        wr(B, 32'h1);
        ticks(5);
        rdchk("stop_count7", B + 32'h8, 32'd7);
        wr(B, 32'h0);
        rdchk("stop_count6", B + 32'h8, 32'd6);
        ticks(2);
        rdchk("stop_frozen", B + 32'h8, 32'd6);
        chk_irq("stop_irq", 1'b0);
        wr(B, 32'h1);
        rdchk("stop_idle", B + 32'h8, 32'd6);
        ticks(2);
        rdchk("stop_reload", B + 32'h8, 32'd10);
        wr(B, 32'h0);
        ticks(2);

        wr(B + 32'h4, 32'd2);
        wr(B, 32'h1);
        ticks(4);
        rdchk("im0_count0", B + 32'h8, 32'd0);
        chk_irq("im0_irq_masked", 1'b0);
        tick();
        rdchk("im0_en_cleared", B, 32'h0);
        wr(B, 32'h8);
        chk_irq("im0_flag_cleared", 1'b0);
        rdchk("im0_ctrl", B, 32'h8);
        tick();
        chk_irq("im0_flag_cleared2", 1'b0);

        wr(B + 32'h4, 32'd1);
        wr(B, 32'h9);
        ticks(4);
        chk_irq("rst1_irq_before", 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_irq("rst1_irq_async", 1'b0);
        rdchk("rst1_ctrl", B, 32'h0);
        rdchk("rst1_preset", B + 32'h4, 32'h0);
        reset = 1'b0;
        tick();

        wr(B + 32'h4, 32'd6);
        wr(B, 32'h9);
        ticks(4);
        rdchk("rst2_count4", B + 32'h8, 32'd4);
        reset = 1'b1;
        #1;
        chk_irq("rst2_irq", 1'b0);
        rdchk("rst2_count", B + 32'h8, 32'd0);
        rdchk("rst2_ctrl", B, 32'h0);
        reset = 1'b0;
        ticks(3);
        rdchk("rst2_stays_idle", B + 32'h8, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
